ir_fetch_sequencer: RTL
=======================

# ir_fetch_sequencer

Control sequencer for the 8-bit CPU. It runs the fetch–decode–execute cycle around the instruction register, which is an 8-bit register with an active-low load enable that captures on the rising clock edge. The block drives that register's load enable plus the PC, MAR, memory, accumulator and output strobes. It decodes the captured opcode and counts retired instructions.

## Interface
- RETIRE_W, 8, width of the retired-instruction counter.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous reset, active-high.
- HOLD  in  1  stall request; freezes the sequencer while high.
- MEM_RDY  in  1  memory read data or write accepted this cycle.
- IR  in  8  current instruction-register contents: opcode IR[7:4], operand IR[3:0].
- C_FLAG, Z_FLAG  in  1 each  ALU carry and zero flags.
- IR_EN_N  out  1  active-low instruction-register load enable.
- MAR_EN_N  out  1  active-low MAR load enable.
- ACC_EN_N  out  1  active-low accumulator load enable.
- OUT_EN_N  out  1  active-low output-register load enable.
- PC_INC, PC_LD  out  1 each  PC increment and PC load from bus.
- MEM_RD, MEM_WR  out  1 each  memory strobes.
- BUS_SEL  out  2  bus source: 0=PC, 1=IR[3:0], 2=MEM, 3=ALU.
- ALU_SUB  out  1  ALU performs subtract.
- HALTED  out  1  sequencer is in the HALT state.
- STATE  out  3  encoded state, for debug.
- RETIRED  out  RETIRE_W  count of retired instructions.

## Operation
- The state register is clocked. All strobes are combinational decodes of state, IR, flags, MEM_RDY and HOLD.
- States:
  - FETCH_A=0: MAR_EN_N=0, BUS_SEL=0. Next state FETCH_M.
  - FETCH_M=1: MEM_RD=1, BUS_SEL=2. While MEM_RDY=0, stay. When MEM_RDY=1, assert IR_EN_N=0 and PC_INC=1, then go to DECODE.
  - DECODE=2: act on IR[7:4]:
    - 1 LDA, 2 ADD, 3 SUB, 4 STA: MAR_EN_N=0, BUS_SEL=1, then EXEC_M.
    - 5 LDI: ACC_EN_N=0, BUS_SEL=1.
    - 6 JMP: PC_LD=1, BUS_SEL=1.
    - 7 JC: PC_LD=1, BUS_SEL=1 only if C_FLAG=1.
    - 8 JZ: PC_LD=1, BUS_SEL=1 only if Z_FLAG=1.
    - E OUT: OUT_EN_N=0, BUS_SEL=3.
    - F HLT: go to HALT.
    - 0 and all other codes: NOP.
    - Every case not listed as going to EXEC_M or HALT returns to FETCH_A.
  - EXEC_M=3: wait while MEM_RDY=0. When MEM_RDY=1, act by opcode, then return to FETCH_A:
    - LDA: MEM_RD=1, BUS_SEL=2, ACC_EN_N=0.
    - ADD: MEM_RD=1, ACC_EN_N=0, BUS_SEL=3.
    - SUB: as ADD, plus ALU_SUB=1.
    - STA: MEM_WR=1, BUS_SEL=3.
    - While waiting, MEM_RD or MEM_WR stays asserted and ACC_EN_N stays 1.
  - HALT=4: all strobes inactive, HALTED=1. Leaves only on RST.
- Inactive strobe levels: active-low enables =1, active-high strobes =0, BUS_SEL=0, ALU_SUB=0.
- Flags and IR are sampled in the same cycle as the action that uses them. IR is stable from the edge that ends FETCH_M.
- Retirement:
  - RETIRED increments by 1 on the edge that leaves DECODE back to FETCH_A, or leaves EXEC_M.
  - HLT counts as retired on entry to HALT.
  - The counter wraps modulo 2^RETIRE_W.

## Timing
- Reset:
  - RST=1 at a rising edge sets state=FETCH_A and RETIRED=0.
  - While RST=1, all strobes are forced inactive and HALTED=0.
  - Reset mid-instruction abandons that instruction: no partial strobes, no retirement.
- Priority: RST > HOLD > normal sequencing.
- HOLD=1: state and RETIRED are held and all strobes are inactive in that cycle. Sequencing resumes in the cycle HOLD falls, in the same state. HOLD is ignored in HALT.
- Latency with no wait states and no HOLD:
  - NOP/LDI/JMP/JC/JZ/OUT: 3 cycles.
  - LDA/ADD/SUB/STA: 4 cycles.
  - HLT: 3 cycles to HALT.
  - Each MEM_RDY=0 cycle in FETCH_M or EXEC_M adds exactly 1 cycle.
- IR_EN_N is low for exactly one cycle per instruction and never outside FETCH_M.
- At most one of PC_INC and PC_LD is high in any cycle.

## Test plan
- Reset then IR stream NOP,NOP, MEM_RDY=1 -> states 0,1,2,0,1,2. IR_EN_N low in cycles 2 and 5. RETIRED=2 after 6 cycles.
- LDA with IR=0x1A, MEM_RDY low for 2 cycles in EXEC_M -> 6-cycle instruction. MAR_EN_N=0 with BUS_SEL=1 in DECODE. ACC_EN_N=0 only in the MEM_RDY=1 cycle.
- JC with IR=0x75: C_FLAG=0 -> no PC_LD. C_FLAG=1 -> PC_LD=1 and BUS_SEL=1 in DECODE. Both cases take 3 cycles.
- HOLD=1 for 3 cycles during FETCH_M -> state stays 1 and all strobes inactive. Fetch completes 3 cycles late. RETIRED unchanged during the hold.
- HLT (IR=0xF0) -> HALTED=1 and stays. HOLD/MEM_RDY toggling has no effect. RST=1 for one edge -> state 0, RETIRED=0.
- RST asserted in EXEC_M of STA -> MEM_WR never asserted and RETIRED=0. RETIRE_W=2 with 5 NOPs -> RETIRED wraps to 1.

Source files
------------

// File: rtl/ir_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ir_fetch_sequencer
//  Purpose  : Fetch / decode / execute control sequencer for the 8-bit CPU.
//             Drives the instruction-register load enable together with the
//             PC, MAR, memory, accumulator and output strobes, decodes the
//             captured opcode and counts retired instructions.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK       in   system clock, rising edge
//    RST       in   synchronous reset, active-high
//    HOLD      in   stall request (ignored once halted)
//    MEM_RDY   in   memory read data valid / write accepted this cycle
//    IR[7:0]   in   instruction register: opcode [7:4], operand [3:0]
//    C_FLAG    in   ALU carry flag
//    Z_FLAG    in   ALU zero flag
//    IR_EN_N   out  instruction-register load enable (active-low)
//    MAR_EN_N  out  MAR load enable (active-low)
//    ACC_EN_N  out  accumulator load enable (active-low)
//    OUT_EN_N  out  output-register load enable (active-low)
//    PC_INC    out  program-counter increment
//    PC_LD     out  program-counter load from bus
//    MEM_RD    out  memory read strobe
//    MEM_WR    out  memory write strobe
//    BUS_SEL   out  bus source: 0=PC 1=IR[3:0] 2=MEM 3=ALU
//    ALU_SUB   out  ALU subtract select
//    HALTED    out  sequencer is halted
//    STATE     out  encoded state for debug
//    RETIRED   out  retired-instruction count (wraps)
// ============================================================================
module ir_fetch_sequencer #(
  parameter int RETIRE_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                HOLD,
  input  logic                MEM_RDY,
  input  logic [7:0]          IR,
  input  logic                C_FLAG,
  input  logic                Z_FLAG,
  output logic                IR_EN_N,
  output logic                MAR_EN_N,
  output logic                ACC_EN_N,
  output logic                OUT_EN_N,
  output logic                PC_INC,
  output logic                PC_LD,
  output logic                MEM_RD,
  output logic                MEM_WR,
  output logic [1:0]          BUS_SEL,
  output logic                ALU_SUB,
  output logic                HALTED,
  output logic [2:0]          STATE,
  output logic [RETIRE_W-1:0] RETIRED
);

  typedef enum logic [2:0] {
    ST_FETCH_A = 3'd0,
    ST_FETCH_M = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC_M  = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] BUS_PC   = 2'd0;
  localparam logic [1:0] BUS_OPND = 2'd1;
  localparam logic [1:0] BUS_MEM  = 2'd2;
  localparam logic [1:0] BUS_ALU  = 2'd3;

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                retire;
  logic [3:0]          opcode;
  logic                is_read_op;

  logic                ir_en_n, mar_en_n, acc_en_n, out_en_n;
  logic                pc_inc, pc_ld, mem_rd, mem_wr, alu_sub, halted;
  logic [1:0]          bus_sel;

  // The operand nibble only travels over the datapath bus; the sequencer
  // itself never looks at it.
  logic                unused_operand;
  assign unused_operand = ^IR[3:0];

  assign opcode     = IR[7:4];
  assign is_read_op = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_FETCH_A;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Everything below RST and HOLD gating is only reached on a cycle where the
  // sequencer is allowed to act, so a stalled or reset cycle leaves every
  // strobe at its inactive default and the state/count untouched.
  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    ir_en_n  = 1'b1;
    mar_en_n = 1'b1;
    acc_en_n = 1'b1;
    out_en_n = 1'b1;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    bus_sel  = BUS_PC;
    alu_sub  = 1'b0;
    halted   = 1'b0;

    if (!RST) begin
      if (state_q == ST_HALT) begin
        halted = 1'b1;
      end else if (!HOLD) begin
        case (state_q)
          ST_FETCH_A: begin
            mar_en_n = 1'b0;
            bus_sel  = BUS_PC;
            state_d  = ST_FETCH_M;
          end

          ST_FETCH_M: begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            if (MEM_RDY) begin
              ir_en_n = 1'b0;
              pc_inc  = 1'b1;
              state_d = ST_DECODE;
            end
          end

          ST_DECODE: begin
            // Single-cycle instructions retire here; memory operations
            // retire later in EXEC_M and clear the flag again.
            state_d = ST_FETCH_A;
            retire  = 1'b1;
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                mar_en_n = 1'b0;
                bus_sel  = BUS_OPND;
                state_d  = ST_EXEC_M;
                retire   = 1'b0;
              end
              OP_LDI: begin
                acc_en_n = 1'b0;
                bus_sel  = BUS_OPND;
              end
              OP_JMP: begin
                pc_ld   = 1'b1;
                bus_sel = BUS_OPND;
              end
              OP_JC: begin
                if (C_FLAG) begin
                  pc_ld   = 1'b1;
                  bus_sel = BUS_OPND;
                end
              end
              OP_JZ: begin
                if (Z_FLAG) begin
                  pc_ld   = 1'b1;
                  bus_sel = BUS_OPND;
                end
              end
              OP_OUT: begin
                out_en_n = 1'b0;
                bus_sel  = BUS_ALU;
              end
              OP_HLT: begin
                state_d = ST_HALT;
              end
              default: begin
              end
            endcase
          end

          ST_EXEC_M: begin
            // The memory strobe is held through wait states; the data is
            // only consumed in the cycle memory reports ready.
            mem_rd = is_read_op;
            mem_wr = (opcode == OP_STA);
            if (MEM_RDY) begin
              state_d = ST_FETCH_A;
              retire  = 1'b1;
              case (opcode)
                OP_LDA: begin
                  acc_en_n = 1'b0;
                  bus_sel  = BUS_MEM;
                end
                OP_ADD: begin
                  acc_en_n = 1'b0;
                  bus_sel  = BUS_ALU;
                end
                OP_SUB: begin
                  acc_en_n = 1'b0;
                  bus_sel  = BUS_ALU;
                  alu_sub  = 1'b1;
                end
                OP_STA: begin
                  bus_sel = BUS_ALU;
                end
                default: begin
                end
              endcase
            end
          end

          default: begin
            state_d = ST_FETCH_A;
          end
        endcase
      end
    end
  end

  assign retired_d = retire ? (retired_q + RETIRE_W'(1)) : retired_q;

  assign IR_EN_N  = ir_en_n;
  assign MAR_EN_N = mar_en_n;
  assign ACC_EN_N = acc_en_n;
  assign OUT_EN_N = out_en_n;
  assign PC_INC   = pc_inc;
  assign PC_LD    = pc_ld;
  assign MEM_RD   = mem_rd;
  assign MEM_WR   = mem_wr;
  assign BUS_SEL  = bus_sel;
  assign ALU_SUB  = alu_sub;
  assign HALTED   = halted;
  assign STATE    = state_q;
  assign RETIRED  = retired_q;

endmodule
`default_nettype wire
